// File: rtl/mgmt_bridge_pkg.sv
// mgmt_bridge_pkg: shared state encoding, opcodes and reply bytes for the
// management UART command bridge.
package mgmt_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    TX
  } state_t;

  // Frame opcodes (first byte of every frame)
  localparam logic [7:0] OP_PING  = 8'hAA;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  // Single-byte replies
  localparam logic [7:0] PONG = 8'h69;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h41;

endpackage

// File: rtl/mgmt_tx_serializer.sv
// mgmt_tx_serializer: holds up to DATA_BYTES response bytes and hands them to
// the UART one at a time, MSB byte first. A byte goes out only while tx_busy
// is low, and never in the cycle right after a previous byte, which covers a
// transmitter whose busy flag rises one cycle late. done pulses with the last
// byte's tx_en.
module mgmt_tx_serializer #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [8*DATA_BYTES-1:0] load_data,
  input  logic [CNT_W-1:0]        load_count,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  output logic                    done
);

  localparam int DW = 8 * DATA_BYTES;

  logic [DW-1:0]    shreg;
  logic [CNT_W-1:0] remaining;
  logic             cooldown;
  logic             fire;

  assign fire    = (remaining != '0) && !tx_busy && !cooldown;
  assign tx_en   = fire;
  assign tx_data = shreg[DW-1 -: 8];
  assign done    = fire && (remaining == CNT_W'(1));

  // Response buffer: load a new reply, or shift out one byte per strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
      cooldown  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      cooldown <= fire;
      if (load) begin
        shreg     <= load_data;
        remaining <= load_count;
      end else if (fire) begin
        shreg     <= shreg << 8;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mgmt_uart_bridge.sv
// mgmt_uart_bridge: parses framed ping/read/write commands arriving as UART
// bytes, runs single register-bus transactions and queues the response for
// the serializer. A per-frame timeout turns stalled frames and unanswered
// reads into a NAK.
// Optional build macro MGMT_UART_BRIDGE_STATS_EN adds saturating NAK and
// dropped-byte counters as two extra output ports.
module mgmt_uart_bridge
  import mgmt_bridge_pkg::*;
#(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_en,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wr_data,
  output logic                    bus_wr_en,
  output logic                    bus_rd_en,
  input  logic [8*DATA_BYTES-1:0] bus_rd_data,
  input  logic                    bus_rd_valid
`ifdef MGMT_UART_BRIDGE_STATS_EN
  ,
  output logic [15:0]             stat_nak_count,
  output logic [15:0]             stat_drop_count
`endif
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BC_W  = $clog2(MAXB + 1);
  localparam int SC_W  = $clog2(DATA_BYTES + 1);

  state_t          state, next_state;
  logic            is_write;
  logic [BC_W-1:0] byte_cnt;
  logic [TW-1:0]   tmr;
  logic            timer_hit;
  logic            addr_last, data_last;

  logic            reload;
  logic            reply;
  logic [7:0]      reply_byte;
  logic            send_nak;
  logic            ld;
  logic [DW-1:0]   ld_data;
  logic [SC_W-1:0] ld_count;
  logic            ser_done;

  assign timer_hit = (tmr == TW'(1));
  assign addr_last = (byte_cnt == BC_W'(ADDR_BYTES - 1));
  assign data_last = (byte_cnt == BC_W'(DATA_BYTES - 1));
  assign bus_rd_en = (state == RD_ISSUE);
  assign bus_wr_en = (state == WR_ISSUE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Frame decode, timer reload requests and response selection
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    next_state = state;
    reload     = 1'b0;
    reply      = 1'b0;
    reply_byte = PONG;
    send_nak   = 1'b0;
    ld         = 1'b0;
    ld_data    = '0;
    ld_count   = '0;
    case (state)
      IDLE: begin
        if (rx_en) begin
          case (rx_data)
            OP_PING:           reply = 1'b1;
            OP_READ, OP_WRITE: begin next_state = ADDR; reload = 1'b1; end
            default:           send_nak = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (rx_en) begin
          reload = 1'b1;
          if (addr_last) next_state = is_write ? DATA : RD_ISSUE;
        end else if (timer_hit) begin
          send_nak = 1'b1;
        end
      end
      DATA: begin
        if (rx_en) begin
          reload = 1'b1;
          if (data_last) next_state = WR_ISSUE;
        end else if (timer_hit) begin
          send_nak = 1'b1;
        end
      end
      RD_ISSUE: begin
        next_state = RD_WAIT;
        reload     = 1'b1;
      end
      RD_WAIT: begin
        if (bus_rd_valid) begin
          ld         = 1'b1;
          ld_data    = bus_rd_data;
          ld_count   = SC_W'(DATA_BYTES);
          next_state = TX;
        end else if (timer_hit) begin
          send_nak = 1'b1;
        end
      end
      WR_ISSUE: begin
        reply      = 1'b1;
        reply_byte = ACK;
      end
      TX: begin
        if (ser_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (reply || send_nak) begin
      ld         = 1'b1;
      ld_data    = DW'(send_nak ? NAK : reply_byte) << (DW - 8);
      ld_count   = SC_W'(1);
      next_state = TX;
    end
  end

  // Frame datapath: opcode flag, byte counter, address/data shifters, timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      tmr         <= '0;
    end else begin
      if (state == IDLE && rx_en) begin
        is_write <= (rx_data == OP_WRITE);
        byte_cnt <= '0;
      end else if (state == ADDR && rx_en) begin
        bus_addr <= (bus_addr << 8) | AW'(rx_data);
        byte_cnt <= addr_last ? '0 : byte_cnt + 1'b1;
      end else if (state == DATA && rx_en) begin
        bus_wr_data <= (bus_wr_data << 8) | DW'(rx_data);
        byte_cnt    <= byte_cnt + 1'b1;
      end
      if (reload)
        tmr <= TW'(TIMEOUT_CYCLES);
      else if ((state == ADDR || state == DATA || state == RD_WAIT) && tmr != '0)
        tmr <= tmr - 1'b1;
    end
  end

  mgmt_tx_serializer #(
    .DATA_BYTES(DATA_BYTES)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_data (ld_data),
    .load_count(ld_count),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .done      (ser_done)
  );

`ifdef MGMT_UART_BRIDGE_STATS_EN
  logic drop;
  assign drop = rx_en && (state == RD_ISSUE || state == RD_WAIT ||
                          state == WR_ISSUE || state == TX);

  // Saturating event counters for NAK replies and discarded bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_nak_count  <= '0;
      stat_drop_count <= '0;
    end else begin
      if (send_nak && stat_nak_count != 16'hFFFF)
        stat_nak_count <= stat_nak_count + 1'b1;
      if (drop && stat_drop_count != 16'hFFFF)
        stat_drop_count <= stat_drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mgmt_uart_bridge.sv
// tb_mgmt_uart_bridge: directed frames for mgmt_uart_bridge with a scoreboard.
// Stimulus pushes expected tx bytes and bus transactions into queues; a
// monitor pops and compares whenever the DUT strobes tx_en or a bus strobe.
module tb_mgmt_uart_bridge;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [31:0] bus_rd_data;
  logic        bus_rd_valid;
`ifdef MGMT_UART_BRIDGE_STATS_EN
  logic [15:0] stat_nak_count;
  logic [15:0] stat_drop_count;
`endif

  mgmt_uart_bridge #(
    .ADDR_BYTES    (1),
    .DATA_BYTES    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_en          (rx_en),
    .tx_data        (tx_data),
    .tx_en          (tx_en),
    .tx_busy        (tx_busy),
    .bus_addr       (bus_addr),
    .bus_wr_data    (bus_wr_data),
    .bus_wr_en      (bus_wr_en),
    .bus_rd_en      (bus_rd_en),
    .bus_rd_data    (bus_rd_data),
    .bus_rd_valid   (bus_rd_valid)
`ifdef MGMT_UART_BRIDGE_STATS_EN
    ,
    .stat_nak_count (stat_nak_count),
    .stat_drop_count(stat_drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } bus_exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          tx_seen = 0;
  int          last_rx_cyc = 0;
  int          busy_len = 3;
  int          busy_left = 0;
  int          exp_nak = 0;
  int          exp_drop = 0;
  bit          tx_fire = 1'b0;
  bit          prev_tx = 1'b0;
  logic [7:0]  exp_tx[$];
  bus_exp_t    exp_bus[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got cycle %0d expected within [%0d,%0d]", name, got, lo, hi);
    end
  endtask

  // Monitor: compares every tx byte and bus strobe against the queues
  initial begin
    bus_exp_t be;
    forever begin
      @(negedge clk);
      if (!rst && tx_en) begin
        tx_seen++;
        tx_fire = 1'b1;
        check("tx_busy_low_at_tx_en", {31'b0, tx_busy}, 32'd0);
        check("tx_en_not_back_to_back", {31'b0, prev_tx}, 32'd0);
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx: got byte %0h expected no byte (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
        end
      end
      prev_tx = tx_en;
      if (!rst && (bus_wr_en || bus_rd_en)) begin
        if (exp_bus.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus_strobe: got wr=%0b rd=%0b addr=%0h expected none (cycle %0d)",
                   bus_wr_en, bus_rd_en, bus_addr, cyc);
        end else begin
          be = exp_bus.pop_front();
          check("bus_strobe_is_write", {31'b0, bus_wr_en}, {31'b0, be.is_wr});
          check("bus_addr", {24'b0, bus_addr}, {24'b0, be.addr});
          if (be.is_wr) check("bus_wr_data", bus_wr_data, be.data);
        end
      end
    end
  end

  // UART transmitter model: busy rises one cycle after tx_en, stays busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_fire) begin
        tx_fire   = 1'b0;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tx_busy = (busy_left > 0);
    end
  end

  // All stimulus tasks start and end 1 ns after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_en       = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_en = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || tx_busy) && i < budget) begin
      tick(1);
      i++;
    end
    check({name, "_tx_pending"}, exp_tx.size(), 0);
    check({name, "_bus_pending"}, exp_bus.size(), 0);
  endtask

  task automatic wait_tx(input int budget, output int got);
    got = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_en) begin
        got = cyc;
        break;
      end
    end
    tick(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_en"}, {31'b0, tx_en}, 32'd0);
    check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({tag, "_bus_addr"}, {24'b0, bus_addr}, 32'd0);
    check({tag, "_bus_wr_data"}, bus_wr_data, 32'd0);
    check({tag, "_bus_wr_en"}, {31'b0, bus_wr_en}, 32'd0);
    check({tag, "_bus_rd_en"}, {31'b0, bus_rd_en}, 32'd0);
`ifdef MGMT_UART_BRIDGE_STATS_EN
    check({tag, "_stat_nak"}, {16'b0, stat_nak_count}, 32'd0);
    check({tag, "_stat_drop"}, {16'b0, stat_drop_count}, 32'd0);
`endif
  endtask

  // Watchdog: the run is a few thousand cycles; anything far beyond is a hang
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int r;
    int seen;
    logic [7:0] data_bytes [4];
    rst          = 1'b1;
    rx_en        = 1'b0;
    rx_data      = 8'h00;
    bus_rd_valid = 1'b0;
    bus_rd_data  = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Ping: reply 0x69 one cycle after the opcode
    exp_tx.push_back(8'h69);
    send_byte(8'hAA);
    @(negedge clk);
    check("ping_latency", {31'b0, tx_en}, 32'd1);
    tick(1);
    drain("ping", 50);

    // Unknown opcode, twice: NAK each, no bus strobe
    for (int k = 0; k < 2; k++) begin
      exp_tx.push_back(8'h41);
      exp_nak++;
      send_byte(8'h55);
      @(negedge clk);
      check("nak_latency", {31'b0, tx_en}, 32'd1);
      tick(1);
      drain("unknown_op", 50);
    end

    // Write 0x01020304 to 0x34, then ACK
    exp_bus.push_back('{is_wr: 1'b1, addr: 8'h34, data: 32'h01020304});
    exp_tx.push_back(8'h06);
    send_byte(8'h57);
    send_byte(8'h34);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    @(negedge clk);
    check("wr_strobe_latency", {31'b0, bus_wr_en}, 32'd1);
    tick(1);
    @(negedge clk);
    check("ack_latency", {31'b0, tx_en}, 32'd1);
    check("wr_data_held", bus_wr_data, 32'h01020304);
    tick(1);
    drain("write", 50);

    // Read 0x12 with slow transmitter; one byte arrives during RD_WAIT and is dropped
    busy_len = 100;
    exp_bus.push_back('{is_wr: 1'b0, addr: 8'h12, data: 32'h0});
    send_byte(8'h52);
    send_byte(8'h12);
    @(negedge clk);
    check("rd_strobe_latency", {31'b0, bus_rd_en}, 32'd1);
    tick(1);
    send_byte(8'h99);
    exp_drop++;
    tick(3);
    bus_rd_data  = 32'hDEADBEEF;
    bus_rd_valid = 1'b1;
    exp_tx.push_back(8'hDE);
    exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    tick(1);
    bus_rd_valid = 1'b0;
    @(negedge clk);
    check("rd_tx_latency", {31'b0, tx_en}, 32'd1);
    tick(1);
    drain("read", 1000);
    busy_len = 3;

    // bus_rd_valid while idle must be ignored
    seen = tx_seen;
    bus_rd_data  = 32'h11223344;
    bus_rd_valid = 1'b1;
    tick(1);
    bus_rd_valid = 1'b0;
    tick(20);
    check("stray_rd_valid_no_tx", tx_seen, seen);

    // Write frame abandoned after the address byte: NAK after the timeout
    exp_tx.push_back(8'h41);
    exp_nak++;
    send_byte(8'h57);
    send_byte(8'h34);
    r = last_rx_cyc;
    wait_tx(300, got);
    check_range("wr_timeout_nak_cycle", got, r + TO, r + TO + 2);
    drain("wr_timeout", 50);

    // Read that never gets bus_rd_valid: NAK after the timeout
    exp_bus.push_back('{is_wr: 1'b0, addr: 8'h10, data: 32'h0});
    exp_tx.push_back(8'h41);
    exp_nak++;
    send_byte(8'h52);
    send_byte(8'h10);
    r = last_rx_cyc;
    wait_tx(400, got);
    check_range("rd_timeout_nak_cycle", got, r + TO + 1, r + TO + 4);
    drain("rd_timeout", 50);

    // Slow write: each byte arrives just inside the timeout, so every byte reloads it
    data_bytes[0] = 8'hA1;
    data_bytes[1] = 8'hB2;
    data_bytes[2] = 8'hC3;
    data_bytes[3] = 8'hD4;
    exp_bus.push_back('{is_wr: 1'b1, addr: 8'h56, data: 32'hA1B2C3D4});
    exp_tx.push_back(8'h06);
    send_byte(8'h57);
    tick(TO - 5);
    send_byte(8'h56);
    for (int k = 0; k < 4; k++) begin
      tick(TO - 5);
      send_byte(data_bytes[k]);
    end
    drain("slow_write", 50);

`ifdef MGMT_UART_BRIDGE_STATS_EN
    check("stat_nak_count", {16'b0, stat_nak_count}, exp_nak);
    check("stat_drop_count", {16'b0, stat_drop_count}, exp_drop);
`endif

    // Reset in the middle of a write frame: outputs clear, no response afterwards
    send_byte(8'h57);
    send_byte(8'h34);
    send_byte(8'h01);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = tx_seen;
    tick(TO + 50);
    check("reset_no_response", tx_seen, seen);

    // Bridge is back in IDLE: a ping answers normally
    exp_tx.push_back(8'h69);
    send_byte(8'hAA);
    @(negedge clk);
    check("post_reset_ping", {31'b0, tx_en}, 32'd1);
    tick(1);
    drain("post_reset", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mgmt_uart_bridge.md
# mgmt_uart_bridge

Byte-level command bridge for the management FPGA. It sits between the UART byte interface (rx_data/rx_en in, tx_data/tx_en out) and a simple register bus. It parses framed ping/read/write commands, issues single bus transactions, and serialises responses back to the UART with flow control. It supersedes the fixed 0xAA→0x69 responder, which it keeps as its ping opcode.

## Interface
Parameters:
- ADDR_BYTES, 1, address bytes per command; bus address width is 8*ADDR_BYTES.
- DATA_BYTES, 4, data bytes per command; bus data width is 8*DATA_BYTES.
- TIMEOUT_CYCLES, 2500000, inter-byte timeout and bus-read timeout (100 ms at 25 MHz).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte.
- rx_en  in  1  rx_data valid, single-cycle pulse.
- tx_data  out  8  byte to transmit.
- tx_en  out  1  transmit strobe, single-cycle pulse.
- tx_busy  in  1  UART transmitter active; may rise up to 1 cycle after tx_en.
- bus_addr  out  8*ADDR_BYTES  transaction address.
- bus_wr_data  out  8*DATA_BYTES  write data.
- bus_wr_en  out  1  write strobe, 1 cycle.
- bus_rd_en  out  1  read strobe, 1 cycle.
- bus_rd_data  in  8*DATA_BYTES  read data.
- bus_rd_valid  in  1  bus_rd_data valid, 1 cycle.

## Operation
- Opcodes, first byte of each frame:
  - 0xAA ping: reply 0x69.
  - 0x52 read: followed by ADDR_BYTES address bytes.
  - 0x57 write: followed by ADDR_BYTES address bytes, then DATA_BYTES data bytes.
  - Any other opcode: reply NAK 0x41.
- All multi-byte fields are MSB first.
- Read: pulse bus_rd_en, then wait for bus_rd_valid. Reply with DATA_BYTES data bytes, MSB first.
- Write: pulse bus_wr_en with bus_addr and bus_wr_data stable, then reply ACK 0x06.
- States:
  - IDLE: on rx_en, decode opcode.
    - Ping, NAK: → TX.
    - Read, write: → ADDR.
  - ADDR: shift bytes into bus_addr. After the last byte: read → RD_ISSUE, write → DATA.
  - DATA: shift bytes into bus_wr_data. After the last byte → WR_ISSUE.
  - RD_ISSUE: assert bus_rd_en → RD_WAIT.
  - RD_WAIT: on bus_rd_valid, latch data → TX.
  - WR_ISSUE: assert bus_wr_en → TX (ACK).
  - TX: emit the queued response bytes → IDLE.
- Timeout counter, width $clog2(TIMEOUT_CYCLES+1):
  - Reloads on entry to ADDR, DATA and RD_WAIT, and on every rx_en in ADDR/DATA.
  - On expiry: discard the frame, send NAK, → IDLE.
- Boundaries:
  - rx_en in RD_ISSUE/RD_WAIT/WR_ISSUE/TX: byte dropped.
  - rx_en coincident with timeout expiry: the byte wins.
  - bus_rd_valid coincident with expiry: the data wins.
  - bus_rd_valid outside RD_WAIT: ignored.
  - Reset mid-frame: partial frame discarded, → IDLE, no response.
- Addresses and data shift left by 8 per byte. bus_addr and bus_wr_data hold their values until the next frame overwrites them.

## Timing
- Reset value of every output is 0. The state machine resets to IDLE.
- Ping or NAK: rx_en at cycle N → tx_en at N+1 (when tx_busy is low).
- Read: last address byte at N → bus_rd_en at N+1. bus_rd_valid at M → first tx_en at M+1.
- Write: last data byte at N → bus_wr_en at N+1 → ACK tx_en at N+2.
- TX rules:
  - tx_en is asserted only when tx_busy is low.
  - tx_en is never asserted in the cycle after a tx_en; this covers the 1-cycle tx_busy lag.
  - tx_data is valid in the tx_en cycle.
- Expiry fires exactly TIMEOUT_CYCLES cycles after the last reload.

## Configuration
- MGMT_UART_BRIDGE_STATS_EN defined: adds two output ports.
  - stat_nak_count (16 bits): counts NAKs sent.
  - stat_drop_count (16 bits): counts dropped rx bytes.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

## Structure
- Package mgmt_bridge_pkg holds:
  - the state enum;
  - opcode constants OP_PING/OP_READ/OP_WRITE;
  - reply constants PONG 0x69, ACK 0x06, NAK 0x41.
- Sub-module mgmt_tx_serializer: loads up to DATA_BYTES bytes plus a count, emits them on tx_en/tx_data under the tx_busy rules, and returns a done pulse.

## Test plan
- Ping: rx 0xAA, tx_busy low → single tx_en with 0x69 one cycle later.
- Read, ADDR_BYTES=1: rx 0x52, 0x12; bus returns 0xDEADBEEF after 5 cycles → bus_rd_en once with bus_addr=0x12, then tx DE AD BE EF. Hold tx_busy high for 100 cycles between bytes; no byte lost or duplicated.
- Write: rx 0x57, 0x34, 01 02 03 04 → bus_wr_en for 1 cycle with bus_addr=0x34 and bus_wr_data=0x01020304, then tx 0x06.
- Unknown opcode: rx 0x55 → tx 0x41; no bus strobe.
- Timeouts (TIMEOUT_CYCLES=100):
  - rx 0x57, 0x34, then silence → 0x41 exactly after expiry, and no bus_wr_en.
  - Read with bus_rd_valid never asserted → 0x41.
- Stats and reset:
  - Stats build: rx 0x55 twice, plus one byte during RD_WAIT → stat_nak_count=2 and stat_drop_count=1.
  - Assert rst mid-frame → all outputs 0 and no response.
